// File: rtl/uart_rx_frontend_pkg.sv
// Shared types and constants for the UART RX pad conditioning front end.
// Glitch counting is built only when UART_RX_FRONTEND_GLITCH_CNT_EN is defined.
package uart_rx_frontend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOW   = 2'b01,
    ST_BREAK = 2'b10
  } brk_st_e;

  localparam int unsigned GlitchCntW    = 8;
  localparam int unsigned FilterLenMin  = 1;
  localparam int unsigned FilterLenMax  = 8;
  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 3;

endpackage

// File: rtl/uart_rx_frontend_sync.sv
// Multi-flop synchronizer for the asynchronous RX pad; resets to line-idle (1).
module uart_rx_frontend_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] r_ff;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ff <= '1;
    else         r_ff <= {r_ff[Stages-2:0], d_i};
  end

  assign q_o = r_ff[Stages-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// RX pad conditioning: synchronizer, stable-window glitch filter, break detector.
// Define UART_RX_FRONTEND_GLITCH_CNT_EN to build the rejected-glitch counter.
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FilterLen  = 4,
  parameter int unsigned BreakCntW  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  filter_en_i,
  input  logic [BreakCntW-1:0]  break_thresh_i,
  input  logic                  glitch_clr_i,
  output logic                  rx_o,
  output logic                  fall_edge_o,
  output logic                  break_o,
  output logic                  break_pulse_o,
  output logic [GlitchCntW-1:0] glitch_cnt_o
);

  if (FilterLen < FilterLenMin || FilterLen > FilterLenMax) begin : g_bad_filter_len
    $error("uart_rx_frontend: FilterLen out of range");
  end
  if (SyncStages < SyncStagesMin || SyncStages > SyncStagesMax) begin : g_bad_sync_stages
    $error("uart_rx_frontend: SyncStages out of range");
  end

  logic w_s;

  uart_rx_frontend_sync #(
    .Stages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rx_i),
    .q_o    (w_s)
  );

  // The window compare includes the current sample, so rx_o moves on the
  // same edge that shifts the FilterLen-th agreeing sample in.
  logic [FilterLen-1:0] w_win_nxt;

  if (FilterLen > 1) begin : g_win
    logic [FilterLen-2:0] r_win;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_win <= '1;
      else         r_win <= w_win_nxt[FilterLen-2:0];
    end
    assign w_win_nxt = {r_win, w_s};
  end else begin : g_nowin
    assign w_win_nxt = w_s;
  end

  logic w_agree;
  logic w_rx_nxt;
  logic r_rx;
  logic r_fall;

  assign w_agree  = (&w_win_nxt) | ~(|w_win_nxt);
  assign w_rx_nxt = filter_en_i ? (w_agree ? w_s : r_rx) : w_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx   <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_rx   <= w_rx_nxt;
      r_fall <= r_rx & ~w_rx_nxt;
    end
  end

  assign rx_o        = r_rx;
  assign fall_edge_o = r_fall;

`ifdef UART_RX_FRONTEND_GLITCH_CNT_EN
  logic                  r_pend;
  logic [GlitchCntW-1:0] r_gcnt;
  logic                  w_glitch;

  // A pending excursion that returns to rx_o without moving it is one glitch.
  assign w_glitch = filter_en_i & r_pend & (w_s == r_rx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= 1'b0;
      r_gcnt <= '0;
    end else begin
      r_pend <= filter_en_i & (w_rx_nxt == r_rx) & (w_s != r_rx);
      if (glitch_clr_i)                 r_gcnt <= '0;
      else if (w_glitch && !(&r_gcnt))  r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign glitch_cnt_o = r_gcnt;
`else
  logic w_unused_glitch_clr;
  assign w_unused_glitch_clr = glitch_clr_i;
  assign glitch_cnt_o        = '0;
`endif

  brk_st_e              r_st;
  logic [BreakCntW-1:0] r_cnt;
  logic [BreakCntW-1:0] w_cnt_inc;
  logic                 w_thr_zero;
  logic                 r_brk;
  logic                 r_bpulse;

  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_thr_zero = (break_thresh_i == '0);

  // r_cnt is the number of rx_o-low cycles seen so far; a threshold of 1 is
  // met by the first one, so IDLE can enter BREAK directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st     <= ST_IDLE;
      r_cnt    <= '0;
      r_brk    <= 1'b0;
      r_bpulse <= 1'b0;
    end else begin
      r_bpulse <= 1'b0;
      case (r_st)
        ST_IDLE: begin
          if (!r_rx && !w_thr_zero) begin
            r_cnt <= BreakCntW'(1);
            if (break_thresh_i == BreakCntW'(1)) begin
              r_st     <= ST_BREAK;
              r_brk    <= 1'b1;
              r_bpulse <= 1'b1;
            end else begin
              r_st <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          if (w_thr_zero || r_rx) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= break_thresh_i) begin
              r_st     <= ST_BREAK;
              r_brk    <= 1'b1;
              r_bpulse <= 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (w_thr_zero || r_rx) begin
            r_st  <= ST_IDLE;
            r_cnt <= '0;
            r_brk <= 1'b0;
          end
        end
        default: begin
          r_st  <= ST_IDLE;
          r_cnt <= '0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign break_o       = r_brk;
  assign break_pulse_o = r_bpulse;

endmodule
